// File: rtl/seqdet_scan_ctrl_if.sv
// Host-side bus of the scan controller: config/start, serial bit stream
// with valid/ready, and the scan result outputs.
interface seqdet_scan_ctrl_if #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 16
);
   logic               start;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic [CNT_W-1:0]   cfg_window;
   logic               din;
   logic               din_valid;
   logic               din_ready;
   logic               busy;
   logic               y;
   logic               done;
   logic               found;
   logic [CNT_W-1:0]   match_count;
   logic [CNT_W-1:0]   first_idx;

   modport master (
      output start, cfg_pattern, cfg_len, cfg_window, din, din_valid,
      input  din_ready, busy, y, done, found, match_count, first_idx
   );

   modport slave (
      input  start, cfg_pattern, cfg_len, cfg_window, din, din_valid,
      output din_ready, busy, y, done, found, match_count, first_idx
   );
endinterface

// File: rtl/seqdet_scan_ctrl.sv
// Programmable serial pattern detector sequenced over a bounded scan window.
// Optional build macro SEQ_STOP_ON_MATCH_EN: end the scan on the first match.
module seqdet_scan_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 16
) (
   input logic               clk,
   input logic               reset,
   seqdet_scan_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   win_q, win_d, bits_q, bits_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, first_q, first_d;
   logic               found_q, found_d, y_q, y_d;

   logic [MAX_LEN-1:0] hist_nxt, mask;
   logic [CNT_W:0]     bits_inc;
   logic               accept, hit, last;

   assign hist_nxt = {hist_q[MAX_LEN-2:0], bus.din};
   assign bits_inc = {1'b0, bits_q} + 1'b1;
   assign accept   = (state_q == SCAN) && bus.din_valid;
   assign last     = (bits_inc == {1'b0, win_q});

   // Only the low len_q history bits take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) mask[i] = (32'(i) < 32'(len_q));
   end

   assign hit = accept && (bits_inc >= (CNT_W+1)'(len_q)) &&
                (((hist_nxt ^ pat_q) & mask) == '0);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      win_d   = win_q;
      hist_d  = hist_q;
      bits_d  = bits_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      found_d = found_q;
      y_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d   = bus.cfg_pattern;
               len_d   = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
               win_d   = bus.cfg_window;
               hist_d  = '0;
               bits_d  = '0;
               cnt_d   = '0;
               first_d = '0;
               found_d = 1'b0;
               state_d = (bus.cfg_len == '0 || bus.cfg_window == '0) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (accept) begin
               hist_d = hist_nxt;
               bits_d = bits_inc[CNT_W-1:0];
               if (hit) begin
                  y_d = 1'b1;
                  if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
                  if (!found_q) begin
                     first_d = bits_q;
                     found_d = 1'b1;
                  end
               end
`ifdef SEQ_STOP_ON_MATCH_EN
               if (last || hit) state_d = DONE;
`else
               if (last) state_d = DONE;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         win_q   <= '0;
         hist_q  <= '0;
         bits_q  <= '0;
         cnt_q   <= '0;
         first_q <= '0;
         found_q <= 1'b0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         win_q   <= win_d;
         hist_q  <= hist_d;
         bits_q  <= bits_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         found_q <= found_d;
         y_q     <= y_d;
      end
   end

   assign bus.din_ready   = (state_q == SCAN);
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.y           = y_q;
   assign bus.found       = found_q;
   assign bus.match_count = cnt_q;
   assign bus.first_idx   = first_q;
endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Randomized and directed bench for seqdet_scan_ctrl against a sliding-window
// reference model; a second CNT_W=4 instance covers counter saturation.
module tb_seqdet_scan_ctrl;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   bits_a [256];

   always #5 clk = ~clk;

   seqdet_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) m_if ();
   seqdet_scan_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(4))     s_if ();

   seqdet_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .reset(reset), .bus(m_if.slave));
   seqdet_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .bus(s_if.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One full scan; expected results come from matching each window slice
   // of the stream against the pattern.
   task automatic run_scan(input logic [7:0] pat, input logic [3:0] len, input logic [15:0] win,
                           input int smin, input int smax, input bit inject);
      int L, n, cnt, first, s;
      bit fnd, degen, ok;
      bit em [256];
      L     = (len > 4'd8) ? 8 : int'(len);
      degen = (L == 0) || (win == 16'd0);
      n = int'(win); cnt = 0; first = 0; fnd = 0;
      for (int i = 0; i < 256; i++) em[i] = 0;
      if (!degen) begin
         for (int i = 0; i < int'(win); i++) begin
            if (i + 1 >= L) begin
               ok = 1;
               for (int j = 0; j < L; j++) if (bits_a[i-j] != pat[j]) ok = 0;
               em[i] = ok;
               if (ok) begin
                  if (!fnd) first = i;
                  fnd = 1;
                  if (cnt < 65535) cnt++;
`ifdef SEQ_STOP_ON_MATCH_EN
                  n = i + 1;
                  break;
`endif
               end
            end
         end
      end

      @(negedge clk);
      m_if.start = 1'b1; m_if.cfg_pattern = pat; m_if.cfg_len = len; m_if.cfg_window = win;
      @(negedge clk);
      m_if.start = 1'b0;
      m_if.cfg_pattern = 8'($urandom); m_if.cfg_len = 4'($urandom); m_if.cfg_window = 16'($urandom);
      chk("busy_after_start", 32'(m_if.busy), 32'd1);
      if (degen) begin
         chk("degen_done", 32'(m_if.done), 32'd1);
         chk("degen_ready", 32'(m_if.din_ready), 32'd0);
         chk("degen_count", 32'(m_if.match_count), 32'd0);
         chk("degen_found", 32'(m_if.found), 32'd0);
         chk("degen_first", 32'(m_if.first_idx), 32'd0);
         @(negedge clk);
         chk("degen_idle", 32'(m_if.busy), 32'd0);
         return;
      end
      chk("scan_no_done", 32'(m_if.done), 32'd0);
      for (int i = 0; i < n; i++) begin
         s = int'($urandom_range(smax, smin));
         repeat (s) begin
            m_if.din_valid = 1'b0; m_if.din = 1'($urandom);
            chk("stall_ready", 32'(m_if.din_ready), 32'd1);
            @(negedge clk);
            chk("stall_y", 32'(m_if.y), 32'd0);
            chk("stall_done", 32'(m_if.done), 32'd0);
         end
         m_if.din_valid = 1'b1; m_if.din = bits_a[i];
         chk("bit_ready", 32'(m_if.din_ready), 32'd1);
         if (inject && i == n / 2) begin
            m_if.start = 1'b1; m_if.cfg_len = 4'd1; m_if.cfg_pattern = ~pat; m_if.cfg_window = 16'd1;
         end
         @(negedge clk);
         m_if.din_valid = 1'b0; m_if.start = 1'b0;
         chk($sformatf("y[%0d]", i), 32'(m_if.y), 32'(em[i]));
         chk($sformatf("done[%0d]", i), 32'(m_if.done), 32'(i == n - 1));
      end
      chk("found", 32'(m_if.found), 32'(fnd));
      chk("match_count", 32'(m_if.match_count), 32'(cnt));
      chk("first_idx", 32'(m_if.first_idx), 32'(first));
      @(negedge clk);
      chk("post_busy", 32'(m_if.busy), 32'd0);
      chk("post_done", 32'(m_if.done), 32'd0);
      chk("post_ready", 32'(m_if.din_ready), 32'd0);
      chk("hold_count", 32'(m_if.match_count), 32'(cnt));
   endtask

   task automatic load_bits(input logic [31:0] v, input int n);
      logic [31:0] t;
      t = v;
      for (int i = 0; i < n; i++) bits_a[i] = t[n-1-i];
   endtask

   initial begin
      int sat_n;
      reset = 1'b1;
      m_if.start = 1'b0; m_if.cfg_pattern = '0; m_if.cfg_len = '0; m_if.cfg_window = '0;
      m_if.din = 1'b0; m_if.din_valid = 1'b0;
      s_if.start = 1'b0; s_if.cfg_pattern = '0; s_if.cfg_len = '0; s_if.cfg_window = '0;
      s_if.din = 1'b0; s_if.din_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(m_if.busy), 32'd0);
      chk("rst_ready", 32'(m_if.din_ready), 32'd0);
      chk("rst_y", 32'(m_if.y), 32'd0);
      chk("rst_done", 32'(m_if.done), 32'd0);
      chk("rst_found", 32'(m_if.found), 32'd0);
      chk("rst_count", 32'(m_if.match_count), 32'd0);
      chk("rst_first", 32'(m_if.first_idx), 32'd0);
      reset = 1'b0;

      load_bits(32'b1101101, 7);
      run_scan(8'h0D, 4'd4, 16'd7, 0, 0, 0);
      load_bits(32'b11110, 5);
      run_scan(8'h0D, 4'd4, 16'd5, 2, 2, 0);
      run_scan(8'h0D, 4'd0, 16'd5, 0, 0, 0);
      run_scan(8'h0D, 4'd4, 16'd0, 0, 0, 0);
      for (int i = 0; i < 12; i++) bits_a[i] = 1'($urandom);
      for (int i = 0; i < 8; i++) bits_a[i+4] = bits_a[i];
      run_scan(8'($urandom), 4'd12, 16'd12, 0, 1, 0);
      load_bits(32'b1111, 4);
      run_scan(8'hFF, 4'd1, 16'd4, 0, 0, 0);
      load_bits(32'b1101101, 7);
      run_scan(8'h0D, 4'd4, 16'd7, 0, 1, 1);

      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < 256; i++) bits_a[i] = ($urandom_range(3, 0) != 0);
         run_scan(8'($urandom), 4'($urandom_range(12, 0)), 16'($urandom_range(24, 0)), 0, 2, bit'(k % 5 == 0));
      end

      // Mid-scan reset: scan aborts with no done pulse.
      @(negedge clk);
      m_if.start = 1'b1; m_if.cfg_pattern = 8'h01; m_if.cfg_len = 4'd1; m_if.cfg_window = 16'd10;
      @(negedge clk);
      m_if.start = 1'b0; m_if.din_valid = 1'b1; m_if.din = 1'b1;
      repeat (2) @(negedge clk);
      m_if.din_valid = 1'b0;
      chk("pre_rst_busy", 32'(m_if.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", 32'(m_if.busy), 32'd0);
      chk("midrst_done", 32'(m_if.done), 32'd0);
      chk("midrst_ready", 32'(m_if.din_ready), 32'd0);
      chk("midrst_count", 32'(m_if.match_count), 32'd0);
      @(negedge clk);
      chk("midrst_done2", 32'(m_if.done), 32'd0);

      // Saturation on the 4-bit counter instance.
`ifdef SEQ_STOP_ON_MATCH_EN
      sat_n = 1;
`else
      sat_n = 15;
`endif
      s_if.start = 1'b1; s_if.cfg_pattern = 8'h01; s_if.cfg_len = 4'd1; s_if.cfg_window = 4'd15;
      @(negedge clk);
      s_if.start = 1'b0; s_if.din_valid = 1'b1; s_if.din = 1'b1;
      for (int i = 0; i < sat_n; i++) begin
         @(negedge clk);
         if (i == sat_n - 1) s_if.din_valid = 1'b0;
         chk($sformatf("sat_y[%0d]", i), 32'(s_if.y), 32'd1);
         chk($sformatf("sat_done[%0d]", i), 32'(s_if.done), 32'(i == sat_n - 1));
      end
      s_if.din_valid = 1'b0;
      chk("sat_count", 32'(s_if.match_count), 32'(sat_n));
      chk("sat_first", 32'(s_if.first_idx), 32'd0);
      @(negedge clk);
      chk("sat_idle", 32'(s_if.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seqdet_scan_ctrl.md
Name: seqdet_scan_ctrl

Overview:
- Controller that sequences a programmable serial pattern detector over a bounded scan window of a 1-bit input stream.
- Latches pattern, length and window on start. Accepts bits under a valid/ready handshake and flags overlapping matches Mealy-style (1101-class detection).
- Reports a done pulse, match count and first-match index to the host/sequencer.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 16, width of window, counters and index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- cfg_pattern  in  MAX_LEN  pattern; bit[len-1] is the first-received bit, bit[0] the last.
- cfg_len  in  LEN_W  pattern length; valid range 1..MAX_LEN.
- cfg_window  in  CNT_W  number of bits to scan.
- din  in  1  serial data bit.
- din_valid  in  1  din valid.
- din_ready  out  1  controller accepts din this cycle.
- busy  out  1  high in SCAN and DONE.
- y  out  1  one-cycle match pulse.
- done  out  1  one-cycle scan-complete pulse.
- found  out  1  at least one match in the last scan.
- match_count  out  CNT_W  matches in the last scan.
- first_idx  out  CNT_W  0-based index of the bit completing the first match.

Behaviour:
- Reset: state IDLE; all outputs 0; history, counters and latched config cleared.
- Reset mid-scan aborts the scan immediately; no done pulse is issued.
- States: IDLE, SCAN, DONE.
- IDLE + start:
  - Latch config.
  - Clear history, bit counter, match_count, first_idx and found.
  - Go to SCAN.
  - If cfg_len==0 or cfg_window==0, go to DONE instead, with zero results.
- cfg_len > MAX_LEN is clamped to MAX_LEN.
- start outside IDLE is ignored. Config inputs are don't-care outside the start cycle.
- SCAN:
  - din_ready=1. A bit is accepted when din_valid & din_ready.
  - Accepted bit shifts into a MAX_LEN history register at the LSB.
  - Match condition: bits_accepted (including this bit) >= len, and history[len-1:0] == pattern[len-1:0]. Matches overlap; history is not cleared on a match.
  - On a match, y=1 in the cycle after acceptance, and match_count increments, saturating at all-ones.
  - On the first match, first_idx = index of the accepted bit and found=1.
  - When the accepted bit is the cfg_window-th bit, go to DONE.
  - No din_valid means no state change; stalls of any length are allowed.
- DONE:
  - Lasts one cycle; done=1, busy=1, din_ready=0.
  - Then go to IDLE.
  - done coincides with y for a match on the final bit.
- IDLE: din_ready=0, busy=0. found, match_count and first_idx hold until the next accepted start.
- Latency: bit accept to y is 1 cycle. Final accept to done is 1 cycle. start to first din_ready is 1 cycle.

Optional Feature:
- Macro SEQ_STOP_ON_MATCH_EN.
- Defined: the scan terminates on the first match. The matching bit's acceptance moves SCAN to DONE. y and done assert in the same cycle; match_count=1. Remaining window bits are not consumed.
- Undefined: the scan always consumes the full cfg_window bits and counts all overlapping matches.

Test Plan:
- Reset defaults: hold reset 3 cycles -> all outputs 0, din_ready=0. Assert reset mid-SCAN -> IDLE next cycle, no done.
- Overlap: pattern=8'h0D, len=4, window=7, stream 1,1,0,1,1,0,1 with continuous valid:
  - y pulses after bits 3 and 6.
  - done one cycle after bit 6.
  - match_count=2, first_idx=3, found=1.
  - With SEQ_STOP_ON_MATCH_EN: done after bit 3, count=1.
- Stalls/no-match: pattern=8'h0D, len=4, window=5, stream 1,1,1,1,0 with din_valid deasserted 2 cycles between each bit -> no y, done after 5th accept, count=0, found=0, first_idx=0.
- Boundaries:
  - len=0 -> done 1 cycle after start with zero results, no din_ready.
  - window=0 -> same.
  - len=12 with MAX_LEN=8 -> behaves as len=8.
  - Pattern all-ones, len=1, window=4, stream 1111 -> count=4, first_idx=0.
- start while busy: assert start mid-SCAN with new config -> ignored; results match the original config.
- Saturation: CNT_W=4, len=1, pattern=1, window=15, stream all ones -> count=15 (all-ones), no wrap.
